// File: rtl/multicycle_main_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_main_fsm
//   Main control FSM for the RV32I multicycle datapath. Sequences the
//   Fetch/Decode/Execute/Memory/Writeback steps, decodes the opcode, drives the
//   datapath mux selects and write enables, and feeds the 2-bit ALUOp to
//   alu_decoder. Unsupported opcodes trap into a sticky ILLEGAL state.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   op             instr[6:0] from the instruction register
//   Zero           ALU zero flag (qualifies beq PC update)
//   mem_ready      memory completed the current access this cycle
//   ALUOp          00 add, 01 subtract, 10 use funct fields
//   ALUSrcA        00 PC, 01 OldPC, 10 rs1 data
//   ALUSrcB        00 rs2 data, 01 ImmExt, 10 constant 4
//   ResultSrc      00 ALUOut, 01 Data, 10 ALUResult
//   ImmSrc         00 I, 01 S, 10 B, 11 J (combinational from op)
//   AdrSrc         0 PC, 1 Result
//   IRWrite, PCWrite, RegWrite, MemWrite   datapath enables
//   instr_retired  one-cycle pulse on the final cycle of each instruction
//   illegal_instr  high while in ILLEGAL
// ---------------------------------------------------------------------------
module multicycle_main_fsm #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic [1:0] ALUOp,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       instr_retired,
   output logic       illegal_instr
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StAluWb    = 4'd7,
      StExecI    = 4'd8,
      StJal      = 4'd9,
      StBeq      = 4'd10,
      StIllegal  = 4'd11
   } state_t;

   state_t r_state;

   // State register with next-state logic folded in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= state_t'(RESET_STATE);
      end else begin
         case (r_state)
            StFetch:    if (mem_ready) r_state <= StDecode;
            StDecode: begin
               case (op)
                  OP_LW, OP_SW: r_state <= StMemAdr;
                  OP_R:         r_state <= StExecR;
                  OP_I:         r_state <= StExecI;
                  OP_JAL:       r_state <= StJal;
                  OP_BEQ:       r_state <= StBeq;
                  default:      r_state <= StIllegal;
               endcase
            end
            // Only lw/sw reach MEMADR and the IR is frozen, so op is still valid.
            StMemAdr:   r_state <= (op == OP_LW) ? StMemRead : StMemWrite;
            StMemRead:  if (mem_ready) r_state <= StMemWb;
            StMemWb:    r_state <= StFetch;
            StMemWrite: if (mem_ready) r_state <= StFetch;
            StExecR:    r_state <= StAluWb;
            StAluWb:    r_state <= StFetch;
            StExecI:    r_state <= StAluWb;
            StJal:      r_state <= StAluWb;
            StBeq:      r_state <= StFetch;
            StIllegal:  r_state <= StIllegal;
            // Encodings 12-15 are unreachable; trap them if ever hit.
            default:    r_state <= StIllegal;
         endcase
      end
   end

   logic [1:0] w_alu_op;
   logic [1:0] w_src_a;
   logic [1:0] w_src_b;
   logic [1:0] w_result_src;
   logic       w_adr_src;
   logic       w_ir_write;
   logic       w_pc_update;
   logic       w_branch;
   logic       w_reg_write;
   logic       w_mem_write;
   logic       w_retired;
   logic       w_illegal;

   // Moore decode of the state register.
   always_comb begin
      w_alu_op     = 2'b00;
      w_src_a      = 2'b00;
      w_src_b      = 2'b00;
      w_result_src = 2'b00;
      w_adr_src    = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_update  = 1'b0;
      w_branch     = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_write  = 1'b0;
      w_retired    = 1'b0;
      w_illegal    = 1'b0;
      case (r_state)
         StFetch: begin
            w_src_b      = 2'b10;
            w_result_src = 2'b10;
            w_ir_write   = mem_ready;
            w_pc_update  = mem_ready;
         end
         StDecode: begin
            // Precompute branch target OldPC + ImmExt.
            w_src_a = 2'b01;
            w_src_b = 2'b01;
         end
         StMemAdr: begin
            w_src_a = 2'b10;
            w_src_b = 2'b01;
         end
         StMemRead: begin
            w_adr_src = 1'b1;
         end
         StMemWb: begin
            w_result_src = 2'b01;
            w_reg_write  = 1'b1;
            w_retired    = 1'b1;
         end
         StMemWrite: begin
            w_adr_src   = 1'b1;
            w_mem_write = 1'b1;
            w_retired   = mem_ready;
         end
         StExecR: begin
            w_src_a  = 2'b10;
            w_alu_op = 2'b10;
         end
         StAluWb: begin
            w_reg_write = 1'b1;
            w_retired   = 1'b1;
         end
         StExecI: begin
            w_src_a  = 2'b10;
            w_src_b  = 2'b01;
            w_alu_op = 2'b10;
         end
         StJal: begin
            w_src_a     = 2'b01;
            w_src_b     = 2'b10;
            w_pc_update = 1'b1;
         end
         StBeq: begin
            w_src_a   = 2'b10;
            w_alu_op  = 2'b01;
            w_branch  = 1'b1;
            w_retired = 1'b1;
         end
         StIllegal: begin
            w_illegal = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      case (op)
         OP_LW, OP_I: ImmSrc = 2'b00;
         OP_SW:       ImmSrc = 2'b01;
         OP_BEQ:      ImmSrc = 2'b10;
         OP_JAL:      ImmSrc = 2'b11;
         default:     ImmSrc = 2'b00;
      endcase
   end

   assign ALUOp         = w_alu_op;
   assign ALUSrcA       = w_src_a;
   assign ALUSrcB       = w_src_b;
   assign ResultSrc     = w_result_src;
   assign AdrSrc        = w_adr_src;
   assign illegal_instr = w_illegal;

   // Enables are gated by rst_n so nothing is written while reset is held,
   // even though mem_ready may be high in the forced FETCH state.
   assign IRWrite       = w_ir_write & rst_n;
   assign PCWrite       = (w_pc_update | (w_branch & Zero)) & rst_n;
   assign RegWrite      = w_reg_write & rst_n;
   assign MemWrite      = w_mem_write & rst_n;
   assign instr_retired = w_retired & rst_n;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
module tb_multicycle_main_fsm;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_SYS = 7'b1110011;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = OP_R;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, instr_retired, illegal_instr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_main_fsm #(.RESET_STATE(4'd0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .op           (op),
      .Zero         (Zero),
      .mem_ready    (mem_ready),
      .ALUOp        (ALUOp),
      .ALUSrcA      (ALUSrcA),
      .ALUSrcB      (ALUSrcB),
      .ResultSrc    (ResultSrc),
      .ImmSrc       (ImmSrc),
      .AdrSrc       (AdrSrc),
      .IRWrite      (IRWrite),
      .PCWrite      (PCWrite),
      .RegWrite     (RegWrite),
      .MemWrite     (MemWrite),
      .instr_retired(instr_retired),
      .illegal_instr(illegal_instr)
   );

   // {ALUOp,ALUSrcA,ALUSrcB,ResultSrc,AdrSrc,IRWrite,PCWrite,RegWrite,MemWrite,retired,illegal}
   wire [14:0] w_obs = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite,
                        RegWrite, MemWrite, instr_retired, illegal_instr};

   // Expected output table per state, written from the state/output list.
   function automatic logic [14:0] exp_vec(int st, logic mr, logic z, logic in_reset);
      logic [1:0] aop, sa, sb, res;
      logic adr, ir, pc, rw, mw, ret, ill;
      {aop, sa, sb, res} = 8'h00;
      {adr, ir, pc, rw, mw, ret, ill} = 7'h00;
      case (st)
         0:  begin sb = 2'b10; res = 2'b10; ir = mr; pc = mr; end
         1:  begin sa = 2'b01; sb = 2'b01; end
         2:  begin sa = 2'b10; sb = 2'b01; end
         3:  begin adr = 1'b1; end
         4:  begin res = 2'b01; rw = 1'b1; ret = 1'b1; end
         5:  begin adr = 1'b1; mw = 1'b1; ret = mr; end
         6:  begin aop = 2'b10; sa = 2'b10; end
         7:  begin rw = 1'b1; ret = 1'b1; end
         8:  begin aop = 2'b10; sa = 2'b10; sb = 2'b01; end
         9:  begin sa = 2'b01; sb = 2'b10; pc = 1'b1; end
         10: begin aop = 2'b01; sa = 2'b10; pc = z; ret = 1'b1; end
         11: begin ill = 1'b1; end
         default: begin end
      endcase
      if (in_reset) {ir, pc, rw, mw, ret} = 5'b0;
      return {aop, sa, sb, res, adr, ir, pc, rw, mw, ret, ill};
   endfunction

   task automatic test_reset();
      int sts[6] = '{0, 1, 0, 1, 6, 7};
      op = OP_R; mem_ready = 1'b1; Zero = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (w_obs !== exp_vec(0, 1'b1, 1'b0, 1'b1)) begin
         errors++; $display("FAIL por_outputs got %b want %b", w_obs, exp_vec(0, 1'b1, 1'b0, 1'b1));
      end
      @(posedge clk); #1; rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (w_obs !== exp_vec(sts[i], 1'b1, 1'b0, 1'b0)) begin
            errors++; $display("FAIL reset_pre cyc%0d got %b want %b", i, w_obs,
                               exp_vec(sts[i], 1'b1, 1'b0, 1'b0));
         end
         @(posedge clk); #1;
      end
      // Now in EXECUTER; pull reset asynchronously between edges.
      #2;
      checks++;
      if (w_obs !== exp_vec(6, 1'b1, 1'b0, 1'b0)) begin
         errors++; $display("FAIL reset_in_execr got %b want %b", w_obs, exp_vec(6, 1'b1, 1'b0, 1'b0));
      end
      rst_n = 1'b0; #1;
      checks++;
      if (w_obs !== exp_vec(0, 1'b1, 1'b0, 1'b1)) begin
         errors++; $display("FAIL reset_async got %b want %b", w_obs, exp_vec(0, 1'b1, 1'b0, 1'b1));
      end
      @(posedge clk); #1;
      checks++;
      if (w_obs !== exp_vec(0, 1'b1, 1'b0, 1'b1)) begin
         errors++; $display("FAIL reset_held got %b want %b", w_obs, exp_vec(0, 1'b1, 1'b0, 1'b1));
      end
      rst_n = 1'b1;
      for (int i = 2; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (w_obs !== exp_vec(sts[i], 1'b1, 1'b0, 1'b0)) begin
            errors++; $display("FAIL reset_post cyc%0d got %b want %b", i, w_obs,
                               exp_vec(sts[i], 1'b1, 1'b0, 1'b0));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_lw();
      int sts[5] = '{0, 1, 2, 3, 4};
      int rw_cnt = 0;
      op = OP_LW; mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (w_obs !== exp_vec(sts[i], 1'b1, Zero, 1'b0)) begin
            errors++; $display("FAIL lw cyc%0d got %b want %b", i, w_obs,
                               exp_vec(sts[i], 1'b1, Zero, 1'b0));
         end
         checks++;
         if (ImmSrc !== 2'b00) begin
            errors++; $display("FAIL lw_immsrc cyc%0d got %b want 00", i, ImmSrc);
         end
         if (RegWrite) rw_cnt++;
         @(posedge clk); #1;
      end
      checks++;
      if (rw_cnt !== 1) begin
         errors++; $display("FAIL lw_regwrite_cycles got %0d want 1", rw_cnt);
      end
   endtask

   task automatic test_lw_wait();
      int   sts[6] = '{0, 1, 2, 3, 3, 4};
      logic mrs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      op = OP_LW;
      for (int i = 0; i < 6; i++) begin
         mem_ready = mrs[i];
         @(negedge clk);
         checks++;
         if (w_obs !== exp_vec(sts[i], mrs[i], Zero, 1'b0)) begin
            errors++; $display("FAIL lw_wait cyc%0d got %b want %b", i, w_obs,
                               exp_vec(sts[i], mrs[i], Zero, 1'b0));
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
   endtask

   task automatic test_sw_wait();
      int   sts[6] = '{0, 1, 2, 5, 5, 5};
      logic mrs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      int   mw_cnt = 0;
      int   ret_cnt = 0;
      op = OP_SW;
      for (int i = 0; i < 6; i++) begin
         mem_ready = mrs[i];
         @(negedge clk);
         checks++;
         if (w_obs !== exp_vec(sts[i], mrs[i], Zero, 1'b0)) begin
            errors++; $display("FAIL sw cyc%0d got %b want %b", i, w_obs,
                               exp_vec(sts[i], mrs[i], Zero, 1'b0));
         end
         checks++;
         if (ImmSrc !== 2'b01) begin
            errors++; $display("FAIL sw_immsrc cyc%0d got %b want 01", i, ImmSrc);
         end
         if (MemWrite) mw_cnt++;
         if (instr_retired) ret_cnt++;
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      checks++;
      if (mw_cnt !== 3) begin
         errors++; $display("FAIL sw_memwrite_cycles got %0d want 3", mw_cnt);
      end
      checks++;
      if (ret_cnt !== 1) begin
         errors++; $display("FAIL sw_retire_pulses got %0d want 1", ret_cnt);
      end
   endtask

   task automatic test_r_and_i();
      // R-type with one fetch wait cycle, then I-ALU.
      int   sts[9] = '{0, 0, 1, 6, 7, 0, 1, 8, 7};
      logic mrs[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 9; i++) begin
         op = (i < 5) ? OP_R : OP_I;
         mem_ready = mrs[i];
         @(negedge clk);
         checks++;
         if (w_obs !== exp_vec(sts[i], mrs[i], Zero, 1'b0)) begin
            errors++; $display("FAIL r_i cyc%0d got %b want %b", i, w_obs,
                               exp_vec(sts[i], mrs[i], Zero, 1'b0));
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
   endtask

   task automatic test_beq();
      int sts[3] = '{0, 1, 10};
      for (int k = 0; k < 2; k++) begin
         int pc_in_beq = 0;
         op = OP_BEQ;
         Zero = (k == 0);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (w_obs !== exp_vec(sts[i], 1'b1, Zero, 1'b0)) begin
               errors++; $display("FAIL beq z%0d cyc%0d got %b want %b", Zero, i, w_obs,
                                  exp_vec(sts[i], 1'b1, Zero, 1'b0));
            end
            checks++;
            if (ImmSrc !== 2'b10) begin
               errors++; $display("FAIL beq_immsrc cyc%0d got %b want 10", i, ImmSrc);
            end
            if (i == 2) pc_in_beq = int'(PCWrite);
            @(posedge clk); #1;
         end
         checks++;
         if (pc_in_beq !== ((k == 0) ? 1 : 0)) begin
            errors++; $display("FAIL beq_pcwrite z%0d got %0d want %0d", Zero, pc_in_beq,
                               (k == 0) ? 1 : 0);
         end
      end
      Zero = 1'b0;
   endtask

   task automatic test_jal();
      int sts[4] = '{0, 1, 9, 7};
      op = OP_JAL;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (w_obs !== exp_vec(sts[i], 1'b1, Zero, 1'b0)) begin
            errors++; $display("FAIL jal cyc%0d got %b want %b", i, w_obs,
                               exp_vec(sts[i], 1'b1, Zero, 1'b0));
         end
         checks++;
         if (ImmSrc !== 2'b11) begin
            errors++; $display("FAIL jal_immsrc cyc%0d got %b want 11", i, ImmSrc);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      int sts[2] = '{0, 1};
      op = OP_SYS; mem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (w_obs !== exp_vec(sts[i], 1'b1, Zero, 1'b0)) begin
            errors++; $display("FAIL ill_entry cyc%0d got %b want %b", i, w_obs,
                               exp_vec(sts[i], 1'b1, Zero, 1'b0));
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < 20; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         Zero = 1'($urandom_range(0, 1));
         op = (i % 2 == 0) ? OP_SYS : OP_LW;  // IR change must not free the trap
         @(negedge clk);
         checks++;
         if (w_obs !== exp_vec(11, mem_ready, Zero, 1'b0)) begin
            errors++; $display("FAIL ill_sticky cyc%0d got %b want %b", i, w_obs,
                               exp_vec(11, mem_ready, Zero, 1'b0));
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b1; Zero = 1'b0; op = OP_R;
      #2; rst_n = 1'b0; #1;
      checks++;
      if (w_obs !== exp_vec(0, 1'b1, 1'b0, 1'b1)) begin
         errors++; $display("FAIL ill_reset got %b want %b", w_obs, exp_vec(0, 1'b1, 1'b0, 1'b1));
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (w_obs !== exp_vec(0, 1'b1, 1'b0, 1'b0)) begin
         errors++; $display("FAIL ill_release got %b want %b", w_obs, exp_vec(0, 1'b1, 1'b0, 1'b0));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lw_wait();
      test_sw_wait();
      test_r_and_i();
      test_beq();
      test_jal();
      test_illegal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
